udp_response_builder: RTL and testbench

Transmit-side counterpart to the request parser: builds outgoing Ethernet/IPv4/UDP frames from a header metadata record and a body AXI-Stream. Each frame carries a fresh 42-byte header and the body realigned behind it. The metadata record holds the addresses of the original request; the block swaps source and destination so the frame returns to the requester. It sits between the body-processing stage and the MAC-facing output stream.

---
 rtl/udp_response_builder_if.sv | 17 +
 rtl/udp_response_builder.sv | 151 +++++++++++++++
 tb/tb_udp_response_builder.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_response_builder_if.sv
// AXI-Stream bundle shared by the body input and the frame output of the response builder.
interface udp_response_builder_if #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_response_builder.sv
// Builds Ethernet/IPv4/UDP response frames: a fresh 42-byte header with swapped
// addresses, followed by the body stream shifted 10 bytes behind the header.
//
// state | meaning
// IDLE  | waiting for metadata, meta_ready high
// HDR0  | emitting header bytes 0-31
// BODY  | emitting 10 carried bytes plus 22 fresh body bytes per beat
// TAIL  | emitting the last carried body bytes after a long final beat
module udp_response_builder #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,
  input  logic [47:0]            meta_src_mac_in,
  input  logic [47:0]            meta_dest_mac_in,
  input  logic [31:0]            meta_src_ip_in,
  input  logic [31:0]            meta_dest_ip_in,
  input  logic [15:0]            meta_src_port_in,
  input  logic [15:0]            meta_dest_port_in,
  input  logic [15:0]            meta_body_len_in,
  input  logic [TUSER_WIDTH-1:0] meta_tuser_in,
  input  logic                   meta_valid,
  output logic                   meta_ready,
  udp_response_builder_if.slave  body_in_axis,
  udp_response_builder_if.master packet_out_axis
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, HDR0, BODY, TAIL} state_t;

  state_t                 state;
  logic [TDATA_WIDTH-1:0] hdr_beat;
  logic [79:0]            carry;
  logic [TUSER_WIDTH-1:0] user_q;
  logic [9:0]             tail_keep;

  logic [15:0]  ip_len, udp_len, frame_len, csum;
  logic [19:0]  csum_sum;
  logic [16:0]  fold1, fold2;
  logic [335:0] hdr_bits;
  logic [255:0] hdr_head;
  logic [79:0]  hdr_tail;
  logic         unused_bits;

  assign unused_bits = ^{meta_tuser_in[15:0], body_in_axis.tuser};

  always_comb begin
    ip_len    = meta_body_len_in + 16'd28;
    udp_len   = meta_body_len_in + 16'd8;
    frame_len = meta_body_len_in + 16'd42;
    csum_sum  = 20'h04500 + 20'(ip_len) + 20'h04000 + 20'h04011
              + 20'(meta_dest_ip_in[31:16]) + 20'(meta_dest_ip_in[15:0])
              + 20'(meta_src_ip_in[31:16]) + 20'(meta_src_ip_in[15:0]);
    fold1     = {1'b0, csum_sum[15:0]} + {13'b0, csum_sum[19:16]};
    fold2     = {1'b0, fold1[15:0]} + {16'b0, fold1[16]};
    csum      = ~fold2[15:0];
    // Addresses are swapped so the frame goes back to the requester.
    hdr_bits  = {meta_src_mac_in, meta_dest_mac_in, 16'h0800,
                 8'h45, 8'h00, ip_len, 16'h0000, 16'h4000, 8'h40, 8'h11, csum,
                 meta_dest_ip_in, meta_src_ip_in,
                 meta_dest_port_in, meta_src_port_in, udp_len, 16'h0000};
    hdr_head  = '0;
    hdr_tail  = '0;
    for (int i = 0; i < 32; i++) hdr_head[8*i +: 8] = hdr_bits[335-8*i -: 8];
    for (int j = 0; j < 10; j++) hdr_tail[8*j +: 8] = hdr_bits[335-8*(32+j) -: 8];
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= IDLE;
      meta_ready <= 1'b0;
      hdr_beat   <= '0;
      carry      <= '0;
      user_q     <= '0;
      tail_keep  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (meta_ready && meta_valid) begin
            hdr_beat   <= hdr_head;
            carry      <= hdr_tail;
            user_q     <= {meta_tuser_in[TUSER_WIDTH-1:16], frame_len};
            meta_ready <= 1'b0;
            state      <= HDR0;
          end else begin
            meta_ready <= 1'b1;
          end
        end
        HDR0: if (packet_out_axis.tready) state <= BODY;
        BODY: begin
          if (body_in_axis.tvalid && packet_out_axis.tready) begin
            carry <= body_in_axis.tdata[255:176];
            if (body_in_axis.tlast) begin
              // tkeep is contiguous, so byte 22 present means more than 22 bytes.
              if (body_in_axis.tkeep[22]) begin
                tail_keep <= body_in_axis.tkeep[31:22];
                state     <= TAIL;
              end else begin
                meta_ready <= 1'b1;
                state      <= IDLE;
              end
            end
          end
        end
        TAIL: begin
          if (packet_out_axis.tready) begin
            meta_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    body_in_axis.tready    = 1'b0;
    packet_out_axis.tvalid = 1'b0;
    packet_out_axis.tlast  = 1'b0;
    packet_out_axis.tdata  = '0;
    packet_out_axis.tkeep  = '0;
    packet_out_axis.tuser  = '0;
    case (state)
      HDR0: begin
        packet_out_axis.tvalid = 1'b1;
        packet_out_axis.tdata  = hdr_beat;
        packet_out_axis.tkeep  = '1;
        packet_out_axis.tuser  = user_q;
      end
      BODY: begin
        body_in_axis.tready    = packet_out_axis.tready;
        packet_out_axis.tvalid = body_in_axis.tvalid;
        packet_out_axis.tdata  = {body_in_axis.tdata[175:0], carry};
        if (body_in_axis.tlast && !body_in_axis.tkeep[22]) begin
          packet_out_axis.tlast = 1'b1;
          packet_out_axis.tkeep = {body_in_axis.tkeep[21:0], 10'h3FF};
        end else begin
          packet_out_axis.tkeep = {TKEEP_WIDTH{1'b1}};
        end
      end
      TAIL: begin
        packet_out_axis.tvalid = 1'b1;
        packet_out_axis.tlast  = 1'b1;
        packet_out_axis.tdata  = {176'b0, carry};
        packet_out_axis.tkeep  = {22'b0, tail_keep};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_udp_response_builder.sv
// Directed frames with a beat scoreboard: expected beats are queued from a byte-level
// frame model when stimulus is driven and compared as the DUT emits them.
module tb_udp_response_builder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [47:0]  meta_src_mac, meta_dest_mac;
  logic [31:0]  meta_src_ip, meta_dest_ip;
  logic [15:0]  meta_src_port, meta_dest_port, meta_body_len;
  logic [127:0] meta_tuser;
  logic         meta_valid, meta_ready;

  udp_response_builder_if body_if ();
  udp_response_builder_if out_if ();

  udp_response_builder dut (
    .axis_aclk(clk), .axis_resetn(rstn),
    .meta_src_mac_in(meta_src_mac), .meta_dest_mac_in(meta_dest_mac),
    .meta_src_ip_in(meta_src_ip), .meta_dest_ip_in(meta_dest_ip),
    .meta_src_port_in(meta_src_port), .meta_dest_port_in(meta_dest_port),
    .meta_body_len_in(meta_body_len), .meta_tuser_in(meta_tuser),
    .meta_valid(meta_valid), .meta_ready(meta_ready),
    .body_in_axis(body_if), .packet_out_axis(out_if)
  );

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [127:0] user;
    logic         last;
  } beat_t;

  typedef struct {
    logic [47:0]  smac, dmac;
    logic [31:0]  sip, dip;
    logic [15:0]  sport, dport;
    logic [127:0] tuser;
  } meta_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           rand_ready = 0;
  int           body_xfers = 0;
  bit           first_seen = 0;
  logic [255:0] first_data;
  logic [127:0] first_user;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare on each transfer, hold check while stalled.
  beat_t        e, pb;
  logic         pv, pr;
  logic [255:0] mask;
  initial begin
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (pv && !pr) begin
          checks++;
          assert ({out_if.tvalid, out_if.tkeep, out_if.tlast, out_if.tuser, out_if.tdata} ===
                  {1'b1, pb.keep, pb.last, pb.user, pb.data})
          else begin
            errors++;
            $error("FAIL stall_hold obs valid=%b keep=%h data=%h exp keep=%h data=%h",
                   out_if.tvalid, out_if.tkeep, out_if.tdata, pb.keep, pb.data);
          end
        end
        if (body_if.tvalid && body_if.tready) body_xfers++;
        if (out_if.tvalid && out_if.tready) begin
          checks++;
          assert (exp_q.size() > 0)
          else begin
            errors++;
            $error("FAIL unexpected_beat obs data=%h exp none", out_if.tdata);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mask = '0;
            for (int i = 0; i < 32; i++) if (e.keep[i]) mask[8*i +: 8] = 8'hFF;
            checks++;
            assert ({out_if.tkeep, out_if.tlast, out_if.tuser, out_if.tdata & mask} ===
                    {e.keep, e.last, e.user, e.data & mask})
            else begin
              errors++;
              $error("FAIL beat obs keep=%h last=%b user=%h data=%h exp keep=%h last=%b user=%h data=%h",
                     out_if.tkeep, out_if.tlast, out_if.tuser, out_if.tdata & mask,
                     e.keep, e.last, e.user, e.data & mask);
            end
          end
          if (!first_seen) begin
            first_seen = 1'b1;
            first_data = out_if.tdata;
            first_user = out_if.tuser;
          end
        end
        pv = out_if.tvalid;
        pr = out_if.tready;
        pb.data = out_if.tdata;
        pb.keep = out_if.tkeep;
        pb.user = out_if.tuser;
        pb.last = out_if.tlast;
      end
    end
  end

  task automatic push_frame(input meta_t m, input int len, input logic [7:0] body[$]);
    logic [7:0] hb[42];
    logic [7:0] f[$];
    int         s;
    int         nb;
    beat_t      b;
    for (int k = 0; k < 6; k++) hb[k] = m.smac[47-8*k -: 8];
    for (int k = 0; k < 6; k++) hb[6+k] = m.dmac[47-8*k -: 8];
    hb[12] = 8'h08; hb[13] = 8'h00; hb[14] = 8'h45; hb[15] = 8'h00;
    hb[16] = 8'((28 + len) >> 8); hb[17] = 8'(28 + len);
    hb[18] = 8'h00; hb[19] = 8'h00; hb[20] = 8'h40; hb[21] = 8'h00;
    hb[22] = 8'h40; hb[23] = 8'h11; hb[24] = 8'h00; hb[25] = 8'h00;
    for (int k = 0; k < 4; k++) hb[26+k] = m.dip[31-8*k -: 8];
    for (int k = 0; k < 4; k++) hb[30+k] = m.sip[31-8*k -: 8];
    hb[34] = m.dport[15:8]; hb[35] = m.dport[7:0];
    hb[36] = m.sport[15:8]; hb[37] = m.sport[7:0];
    hb[38] = 8'((8 + len) >> 8); hb[39] = 8'(8 + len);
    hb[40] = 8'h00; hb[41] = 8'h00;
    s = 0;
    for (int k = 14; k < 34; k += 2) s += {hb[k], hb[k+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    s = ~s;
    hb[24] = 8'(s >> 8);
    hb[25] = 8'(s);
    for (int k = 0; k < 42; k++) f.push_back(hb[k]);
    for (int k = 0; k < len; k++) f.push_back(body[k]);
    nb = (f.size() + 31) / 32;
    for (int bi = 0; bi < nb; bi++) begin
      b.data = '0;
      b.keep = '0;
      for (int i = 0; i < 32; i++) begin
        if (bi*32 + i < f.size()) begin
          b.data[8*i +: 8] = f[bi*32 + i];
          b.keep[i] = 1'b1;
        end
      end
      b.user = (bi == 0) ? {m.tuser[127:16], 16'(42 + len)} : 128'b0;
      b.last = (bi == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_frame(input meta_t m, input int len, input bit gaps, input int abort_after);
    logic [7:0] body[$];
    int         n;
    int         nb;
    bit         aborted;
    for (int k = 0; k < len; k++) body.push_back(8'($urandom));
    push_frame(m, len, body);
    body_xfers = 0;
    meta_src_mac = m.smac; meta_dest_mac = m.dmac;
    meta_src_ip = m.sip; meta_dest_ip = m.dip;
    meta_src_port = m.sport; meta_dest_port = m.dport;
    meta_body_len = 16'(len); meta_tuser = m.tuser;
    meta_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (meta_ready) break;
      n++;
      if (n > 500) begin
        errors++;
        $display("FAIL meta_timeout obs meta_ready=0 exp 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    meta_valid = 1'b0;
    checks++;
    assert ({out_if.tvalid, meta_ready} === 2'b10)
    else begin
      errors++;
      $error("FAIL hdr_latency obs valid,meta_ready=%b exp 10", {out_if.tvalid, meta_ready});
    end
    nb = (len + 31) / 32;
    aborted = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (abort_after >= 0 && b == abort_after) begin
        aborted = 1'b1;
        break;
      end
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      body_if.tdata = '0;
      body_if.tkeep = '0;
      for (int i = 0; i < 32; i++) begin
        if (b*32 + i < len) begin
          body_if.tdata[8*i +: 8] = body[b*32 + i];
          body_if.tkeep[i] = 1'b1;
        end
      end
      body_if.tlast = (b == nb - 1);
      body_if.tvalid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (body_if.tready) break;
        n++;
        if (n > 500) begin
          errors++;
          $display("FAIL body_timeout obs tready=0 exp 1");
          break;
        end
      end
      @(posedge clk);
      #1;
      body_if.tvalid = 1'b0;
      body_if.tlast = 1'b0;
    end
    if (!aborted) begin
      checks++;
      assert (body_xfers === nb)
      else begin
        errors++;
        $error("FAIL body_xfers obs %0d exp %0d", body_xfers, nb);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    assert (exp_q.size() == 0)
    else begin
      errors++;
      $error("FAIL drain_%s obs pending=%0d exp 0", tag, exp_q.size());
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({meta_ready, body_if.tready, out_if.tvalid, out_if.tlast,
             out_if.tdata, out_if.tkeep, out_if.tuser} === '0)
    else begin
      errors++;
      $error("FAIL zero_%s obs mr=%b br=%b v=%b l=%b data=%h keep=%h exp all 0",
             tag, meta_ready, body_if.tready, out_if.tvalid, out_if.tlast,
             out_if.tdata, out_if.tkeep);
    end
  endtask

  meta_t ma, mb, mc;

  initial begin
    meta_valid = 1'b0;
    meta_src_mac = '0; meta_dest_mac = '0; meta_src_ip = '0; meta_dest_ip = '0;
    meta_src_port = '0; meta_dest_port = '0; meta_body_len = '0; meta_tuser = '0;
    body_if.tdata = '0; body_if.tkeep = '0; body_if.tuser = '0;
    body_if.tvalid = 1'b0; body_if.tlast = 1'b0;

    ma = '{smac: 48'h020000000001, dmac: 48'h020000000002, sip: 32'h0A000001,
           dip: 32'h0A000002, sport: 16'd5000, dport: 16'd6000,
           tuser: 128'hA5A5_5A5A_1234_5678_9ABC_DEF0_1357_FFFF};
    mb = '{smac: 48'h001122334455, dmac: 48'h66778899AABB, sip: 32'hC0A80105,
           dip: 32'hC0A801FE, sport: 16'd1234, dport: 16'd53,
           tuser: 128'h1111_2222_3333_4444_5555_6666_7777_8888};
    mc = '{smac: 48'hDEADBEEF0001, dmac: 48'hCAFEF00D0002, sip: 32'hAC100001,
           dip: 32'hAC1000FF, sport: 16'd40000, dport: 16'd8080,
           tuser: 128'hFEDC_BA98_7654_3210_0F0F_F0F0_AAAA_5555};

    repeat (3) @(posedge clk);
    #1;
    check_zero("in_reset");
    rstn = 1'b1;
    #1;
    check_zero("at_release");
    @(posedge clk);
    #1;
    checks++;
    assert (meta_ready === 1'b1)
    else begin
      errors++;
      $error("FAIL meta_ready_rise obs %b exp 1", meta_ready);
    end

    send_frame(ma, 22, 1'b0, -1);
    drain("l22");
    checks++;
    assert ({first_data[199:192], first_data[207:200]} === 16'h26B9)
    else begin
      errors++;
      $error("FAIL ip_csum obs %h exp 26b9", {first_data[199:192], first_data[207:200]});
    end
    checks++;
    assert ({first_data[135:128], first_data[143:136]} === 16'h0032)
    else begin
      errors++;
      $error("FAIL ip_total_len obs %h exp 0032", {first_data[135:128], first_data[143:136]});
    end
    checks++;
    assert ({first_data[215:208], first_data[223:216], first_data[231:224], first_data[239:232]} === 32'h0A000002)
    else begin
      errors++;
      $error("FAIL ip_src obs %h exp 0a000002",
             {first_data[215:208], first_data[223:216], first_data[231:224], first_data[239:232]});
    end
    checks++;
    assert (first_user[15:0] === 16'd64)
    else begin
      errors++;
      $error("FAIL tuser_len obs %0d exp 64", first_user[15:0]);
    end

    send_frame(mb, 23, 1'b0, -1);
    drain("l23");
    send_frame(mc, 1, 1'b0, -1);
    drain("l1");

    rand_ready = 1'b1;
    send_frame(ma, 200, 1'b1, -1);
    drain("l200");
    send_frame(mb, 55, 1'b1, -1);
    drain("l55");
    rand_ready = 1'b0;

    send_frame(mb, 40, 1'b0, -1);
    send_frame(mc, 50, 1'b0, -1);
    drain("b2b");

    send_frame(mc, 100, 1'b0, 1);
    rstn = 1'b0;
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send_frame(ma, 22, 1'b0, -1);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
